// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter and the slave interfaces behind it.
package apb_arb_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    // Read data returned when a transfer is forcibly terminated; slaves use the same pattern
    localparam logic [31:0] APB_ERR_DATA = 32'hBAD1_BAD1;

    // Width of the ACCESS-phase timeout counter
    function automatic int unsigned timeout_cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting after the last winner,
// with a registered pointer that only moves when the grant is taken (en_i).
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               gnt_any_o
);

    logic [IdxW-1:0] ptr_q;

    // Search from ptr+1 upwards (wrapping); first pending requester wins
    always_comb begin
        int unsigned     idx;
        logic [IdxW-1:0] cand;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = off + 32'(ptr_q);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IdxW'(idx);
            if (!gnt_any_o && req_i[cand]) begin
                gnt_any_o   = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

    // Pointer resets to the last index so requester 0 is searched first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IdxW'(NUM_REQ - 1);
        end else if (en_i && gnt_any_o) begin
            ptr_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters. A round-robin winner is granted
// in IDLE, then a SETUP/ACCESS transfer is sequenced with a bounded PREADY wait, and the
// completion (data + error) is returned to the owner as a one-cycle pulse.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    apb_state_e state_q, state_d;

    logic [31:0]        paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               gnt_any;
    logic               grant_en;
    logic               complete;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_write;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_arbiter (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_valid),
        .en_i      (grant_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // Select the winning requester's command fields
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_write = req_write[i];
            end
        end
    end

    // Next-state logic for the transfer sequencer and its registered outputs
    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        grant_en     = 1'b0;
        complete     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    grant_en = 1'b1;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_wdata;
                    pwrite_d = sel_write;
                    owner_d  = gnt_idx;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    complete     = 1'b1;
                    resp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
                    resp_err_d   = PSLVERR;
                end else if (cnt_q == CntLast) begin
                    // Slave never answered: terminate so the bus cannot hang
                    complete     = 1'b1;
                    resp_rdata_d = APB_ERR_DATA;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (complete) begin
            psel_d                = 1'b0;
            penable_d             = 1'b0;
            paddr_d               = '0;
            pwdata_d              = '0;
            pwrite_d              = 1'b0;
            resp_valid_d[owner_q] = 1'b1;
            state_d               = StIdle;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command, APB outputs, timeout counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            owner_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Grant pulse is combinational in IDLE; forced low while reset is held
    assign req_ready  = (state_q == StIdle && !rst) ? gnt : '0;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PWRITE     = pwrite_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: behavioural APB slave with programmable wait
// states, per-scenario tasks, and a response scoreboard.
module tb_apb_master_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Slave model state
    int          waits = 0;
    int          acc_cnt;
    logic [31:0] mem [16];
    logic        mapped;

    apb_master_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 clk = ~clk;

    // APB slave: 16 words at 0x00-0x3F, word 1 preset to 0xA5, anything else errors
    assign mapped  = (PADDR < 32'h40);
    assign PREADY  = (acc_cnt >= waits);
    assign PRDATA  = mapped ? mem[PADDR[5:2]] : 32'hBAD1_BAD1;
    assign PSLVERR = !mapped;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? 32'h0000_00A5 : 32'h0;
            acc_cnt <= 0;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY && PWRITE && mapped) mem[PADDR[5:2]] <= PWDATA;
        end
    end

    // Scoreboard monitor: every completion pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid !== 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_resp: got resp_valid=%b required none", resp_valid);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (resp_valid !== 2'(1 << e.owner)) begin
                        failures++;
                        $display("FAIL sb_owner: got %b required %b", resp_valid, 2'(1 << e.owner));
                    end
                    checks++;
                    if (resp_rdata !== e.rdata) begin
                        failures++;
                        $display("FAIL sb_rdata: got %h required %h", resp_rdata, e.rdata);
                    end
                    checks++;
                    if (resp_err !== e.err) begin
                        failures++;
                        $display("FAIL sb_err: got %b required %b", resp_err, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic expect_resp(input int owner, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.owner = owner;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
        if (idx == 0) begin
            req_valid[0] = 1'b1; req_write[0] = wr;
            req_addr[31:0] = addr; req_wdata[31:0] = wdata;
        end else begin
            req_valid[1] = 1'b1; req_write[1] = wr;
            req_addr[63:32] = addr; req_wdata[63:32] = wdata;
        end
    endtask

    // Issue one request from an otherwise idle bus and follow it to its completion pulse
    task automatic run_one(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic granted,
                           output logic psel1, output logic pen1, output logic pen2,
                           output logic [31:0] paddr1);
        lat  = 0;
        pen2 = 1'b0;
        @(negedge clk);
        set_req(idx, wr, addr, wdata);
        #1;
        granted = (req_ready === 2'(1 << idx));
        @(negedge clk);
        req_valid = '0;
        #1;
        psel1  = PSEL;
        pen1   = PENABLE;
        paddr1 = PADDR;
        lat    = 1;
        while (lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == 2) pen2 = PENABLE;
            if (resp_valid[idx]) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            failures++;
            $display("FAIL reset_apb: got %b/%b/%b %h %h required all 0", PSEL, PENABLE, PWRITE,
                     PADDR, PWDATA);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_req_ready: got %b required 00", req_ready);
        end
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_resp: got %b %b %h required all 0", resp_valid, resp_err,
                     resp_rdata);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({PSEL, req_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release_idle: got psel=%b req_ready=%b required 0/00", PSEL,
                     req_ready);
        end
    endtask

    task automatic test_contention();
        int          cnt [2];
        logic [31:0] dat [2];
        logic [1:0]  pend;
        logic [1:0]  exp_rdy;
        int          own;
        dat[0] = 32'h1111_0000;
        dat[1] = 32'h2222_0001;
        cnt[0] = 0;
        cnt[1] = 0;
        pend   = 2'b11;
        expect_resp(0, 32'h0, 1'b0);
        expect_resp(1, 32'h0, 1'b0);
        expect_resp(0, 32'h0, 1'b0);
        expect_resp(1, 32'h0, 1'b0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            req_valid = pend;
            req_write = 2'b11;
            req_addr  = {32'h0000_0014, 32'h0000_0010};
            req_wdata = {dat[1], dat[0]};
            #1;
            case (k)
                0, 6:    exp_rdy = 2'b01;
                3, 9:    exp_rdy = 2'b10;
                default: exp_rdy = 2'b00;
            endcase
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL contention_grant cycle %0d: got %b required %b", k, req_ready,
                         exp_rdy);
            end
            if (k == 1 || k == 4 || k == 7 || k == 10) begin
                own = (k == 4 || k == 10) ? 1 : 0;
                checks++;
                if ({PSEL, PWRITE, PWDATA} !== {2'b11, dat[own]}) begin
                    failures++;
                    $display("FAIL contention_setup cycle %0d: got psel=%b pwrite=%b pwdata=%h required 1/1/%h",
                             k, PSEL, PWRITE, PWDATA, dat[own]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) pend[i] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single_read();
        int          lat;
        logic        g, s1, e1, e2;
        logic [31:0] a1;
        expect_resp(0, 32'h0000_00A5, 1'b0);
        run_one(0, 1'b0, 32'h0000_0004, 32'h0, lat, g, s1, e1, e2, a1);
        checks++;
        if (g !== 1'b1) begin
            failures++;
            $display("FAIL single_read_grant: got %b required 1", g);
        end
        checks++;
        if ({s1, e1, e2} !== 3'b101) begin
            failures++;
            $display("FAIL single_read_phases: got psel1=%b pen1=%b pen2=%b required 1/0/1", s1,
                     e1, e2);
        end
        checks++;
        if (a1 !== 32'h0000_0004) begin
            failures++;
            $display("FAIL single_read_paddr: got %h required 00000004", a1);
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL single_read_latency: got %0d required 3", lat);
        end
    endtask

    task automatic test_slave_error();
        int          lat;
        logic        g, s1, e1, e2;
        logic [31:0] a1;
        expect_resp(0, 32'hBAD1_BAD1, 1'b1);
        run_one(0, 1'b0, 32'h0000_0100, 32'h0, lat, g, s1, e1, e2, a1);
        checks++;
        if ({g, lat} !== {1'b1, 32'd3}) begin
            failures++;
            $display("FAIL slave_error_timing: got grant=%b lat=%0d required 1/3", g, lat);
        end
    endtask

    task automatic test_wait_states();
        int          lat;
        logic        g, s1, e1, e2;
        logic [31:0] a1;
        waits = 3;
        expect_resp(0, 32'h0000_00A5, 1'b0);
        run_one(0, 1'b0, 32'h0000_0004, 32'h0, lat, g, s1, e1, e2, a1);
        waits = 0;
        checks++;
        if (lat !== 6) begin
            failures++;
            $display("FAIL wait_states_latency: got %0d required 6", lat);
        end
    endtask

    task automatic test_timeout();
        int          lat;
        logic        g, s1, e1, e2;
        logic [31:0] a1;
        waits = 1000;
        expect_resp(0, 32'hBAD1_BAD1, 1'b1);
        run_one(0, 1'b0, 32'h0000_0008, 32'h0, lat, g, s1, e1, e2, a1);
        checks++;
        if (lat !== 18) begin
            failures++;
            $display("FAIL timeout_latency: got %0d required 18", lat);
        end
        checks++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_psel_drop: got psel=%b penable=%b required 0/0", PSEL, PENABLE);
        end
        waits = 0;
    endtask

    task automatic test_back_to_back();
        int lat;
        expect_resp(1, 32'h0, 1'b0);
        expect_resp(1, 32'h0000_0055, 1'b0);
        @(negedge clk);
        set_req(1, 1'b1, 32'h0, 32'h0000_0055);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL b2b_first_grant: got %b required 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if ({resp_valid, req_ready} !== 4'b1010) begin
            failures++;
            $display("FAIL b2b_overlap: got resp_valid=%b req_ready=%b required 10/10", resp_valid,
                     req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if ({PSEL, PWRITE, PADDR} !== {2'b10, 32'h0}) begin
            failures++;
            $display("FAIL b2b_second_setup: got psel=%b pwrite=%b paddr=%h required 1/0/0", PSEL,
                     PWRITE, PADDR);
        end
        lat = 1;
        while (lat < 40 && !resp_valid[1]) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL b2b_second_latency: got %0d required 3", lat);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat;
        waits = 1000;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0000_0008, 32'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midrst_grant: got %b required 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_in_access: got psel=%b penable=%b required 1/1", PSEL, PENABLE);
        end
        rst = 1'b1;
        waits = 0;
        set_req(0, 1'b0, 32'h0000_0004, 32'h0);
        set_req(1, 1'b0, 32'h0000_0004, 32'h0);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            failures++;
            $display("FAIL midrst_apb_clear: got %b/%b/%b %h %h required all 0", PSEL, PENABLE,
                     PWRITE, PADDR, PWDATA);
        end
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== '0) begin
            failures++;
            $display("FAIL midrst_resp_clear: got %b %b %b %h required all 0", req_ready,
                     resp_valid, resp_err, resp_rdata);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (resp_valid !== 2'b00) begin
                failures++;
                $display("FAIL midrst_no_resp: got %b required 00", resp_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        expect_resp(0, 32'h0000_00A5, 1'b0);
        expect_resp(1, 32'h0000_00A5, 1'b0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midrst_priority: got %b required 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL midrst_second_grant: got %b required 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        lat = 1;
        while (lat < 40 && !resp_valid[1]) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL midrst_second_latency: got %0d required 3", lat);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_slave_error();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d outstanding responses required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
